// File: rtl/ram_scanout_if.sv
// ---------------------------------------------------------------------------
// ram_scanout_if
//   Bundles everything that crosses the ram_scanout boundary except clock and
//   reset: the request inputs, the screen-RAM port and the pixel stream.
//
//   master : the scanout engine (drives RAM address/data/load, pixel stream,
//            status; receives requests, RAM read data and pixel_ready).
//   slave  : the environment (requesting logic, RAM, pixel sink).
// ---------------------------------------------------------------------------
interface ram_scanout_if;
  // requests
  logic        start;
  logic        clear;
  logic [15:0] fill;

  // screen RAM port (read data is combinational from ram_address)
  logic [11:0] ram_address;
  logic [15:0] ram_in;
  logic        ram_load;
  logic [15:0] ram_out;

  // serial pixel stream
  logic        pixel;
  logic        pixel_valid;
  logic        pixel_ready;
  logic        line_start;
  logic        frame_start;

  // status
  logic        busy;
  logic        done;

  modport master (
    input  start, clear, fill, ram_out, pixel_ready,
    output ram_address, ram_in, ram_load,
           pixel, pixel_valid, line_start, frame_start,
           busy, done
  );

  modport slave (
    output start, clear, fill, ram_out, pixel_ready,
    input  ram_address, ram_in, ram_load,
           pixel, pixel_valid, line_start, frame_start,
           busy, done
  );
endinterface

// File: rtl/ram_scanout.sv
// ---------------------------------------------------------------------------
// ram_scanout
//   Read-side initiator for the screen RAM. Streams the frame out as a serial
//   1-bit pixel stream (LSB first within each 16-bit word) under a
//   valid/ready handshake, or bulk-fills every word with one value.
//
// Ports
//   clk            system clock, rising edge
//   rst_n          asynchronous active-low reset
//   bus (master)   start/clear/fill requests, RAM address/write port,
//                  pixel/pixel_valid/pixel_ready stream with line_start and
//                  frame_start markers, busy and done status
//
// Parameters
//   WORDS_PER_LINE words per display line
//   LINES          lines per frame; WORDS_PER_LINE*LINES must be 1..4096
// ---------------------------------------------------------------------------
module ram_scanout #(
  parameter int WORDS_PER_LINE = 16,
  parameter int LINES          = 240
) (
  input  logic          clk,
  input  logic          rst_n,
  ram_scanout_if.master bus
);

  localparam int          DEPTH     = WORDS_PER_LINE * LINES;
  localparam logic [11:0] LAST_WORD = 12'(DEPTH - 1);

  generate
    if (DEPTH < 1 || DEPTH > 4096) begin : g_depth_check
      $error("ram_scanout: WORDS_PER_LINE*LINES must be within 1..4096");
    end
  endgenerate

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    FETCH,
    SHIFT,
    DONE
  } state_t;

  state_t      state_reg,    state_next;
  logic [11:0] word_cnt_reg, word_cnt_next;
  logic [3:0]  bit_cnt_reg,  bit_cnt_next;
  logic [15:0] shift_reg,    shift_next;
  logic [15:0] fill_reg,     fill_next;

  logic in_clear;
  logic in_fetch;
  logic in_shift;
  logic line_head;

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      word_cnt_reg <= '0;
      bit_cnt_reg  <= '0;
      shift_reg    <= '0;
      fill_reg     <= '0;
    end else begin
      state_reg    <= state_next;
      word_cnt_reg <= word_cnt_next;
      bit_cnt_reg  <= bit_cnt_next;
      shift_reg    <= shift_next;
      fill_reg     <= fill_next;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_next    = state_reg;
    word_cnt_next = word_cnt_reg;
    bit_cnt_next  = bit_cnt_reg;
    shift_next    = shift_reg;
    fill_next     = fill_reg;

    case (state_reg)
      IDLE: begin
        // clear has priority when both requests arrive together
        if (bus.clear) begin
          state_next    = CLEAR;
          word_cnt_next = '0;
          fill_next     = bus.fill;
        end else if (bus.start) begin
          state_next    = FETCH;
          word_cnt_next = '0;
        end
      end

      CLEAR: begin
        // counter parks on the last address instead of wrapping
        if (word_cnt_reg == LAST_WORD) begin
          state_next = DONE;
        end else begin
          word_cnt_next = word_cnt_reg + 12'd1;
        end
      end

      FETCH: begin
        // RAM read is combinational, so the word is valid this cycle
        shift_next   = bus.ram_out;
        bit_cnt_next = '0;
        state_next   = SHIFT;
      end

      SHIFT: begin
        // shift and bit counter only move on a transfer, which keeps
        // pixel and the markers stable while the sink stalls
        if (bus.pixel_ready) begin
          shift_next   = {1'b0, shift_reg[15:1]};
          bit_cnt_next = bit_cnt_reg + 4'd1;
          if (bit_cnt_reg == 4'd15) begin
            if (word_cnt_reg == LAST_WORD) begin
              state_next = DONE;
            end else begin
              word_cnt_next = word_cnt_reg + 12'd1;
              state_next    = FETCH;
            end
          end
        end
      end

      DONE: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Outputs, decoded from registered state only
  // -------------------------------------------------------------------------
  assign in_clear  = (state_reg == CLEAR);
  assign in_fetch  = (state_reg == FETCH);
  assign in_shift  = (state_reg == SHIFT);
  assign line_head = ((32'(word_cnt_reg) % WORDS_PER_LINE) == 0);

  assign bus.ram_load    = in_clear;
  assign bus.ram_in      = in_clear ? fill_reg : 16'h0000;
  assign bus.ram_address = (in_clear || in_fetch) ? word_cnt_reg : 12'h000;

  assign bus.pixel_valid = in_shift;
  assign bus.pixel       = in_shift & shift_reg[0];
  assign bus.line_start  = in_shift && (bit_cnt_reg == 4'd0) && line_head;
  assign bus.frame_start = in_shift && (bit_cnt_reg == 4'd0) && (word_cnt_reg == 12'h000);

  assign bus.busy = in_clear || in_fetch || in_shift;
  assign bus.done = (state_reg == DONE);

endmodule

// File: tb/tb_ram_scanout.sv
// ---------------------------------------------------------------------------
// tb_ram_scanout
//   Bench for ram_scanout with a reduced frame (16 words x 8 lines) so that
//   several complete scans fit in a short run. A behavioural screen RAM with
//   combinational read sits on the RAM port; the bench can also load it
//   through a side write port while the DUT is idle. Expected pixels are
//   pushed to a queue when a scan is requested and popped on each transfer.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ram_scanout;

  localparam int WPL      = 16;
  localparam int LINES    = 8;
  localparam int DEPTH    = WPL * LINES;
  localparam int NPIX     = DEPTH * 16;
  localparam int LINE_PIX = WPL * 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ram_scanout_if bus ();

  ram_scanout #(
    .WORDS_PER_LINE (WPL),
    .LINES          (LINES)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // behavioural screen RAM
  logic [15:0] mem [0:4095];
  logic        tb_we   = 1'b0;
  logic [11:0] tb_addr = 12'h000;
  logic [15:0] tb_data = 16'h0000;

  assign bus.ram_out = mem[bus.ram_address];

  always @(posedge clk) begin
    if (bus.ram_load) mem[bus.ram_address] <= bus.ram_in;
    else if (tb_we)   mem[tb_addr]         <= tb_data;
  end

  int   n_checks = 0;
  int   n_fail   = 0;
  logic exp_q[$];

  function automatic logic [15:0] preload_word(input int n);
    if (n == DEPTH - 1) return 16'h0EFF;
    return 16'(n);
  endfunction

  function automatic logic [34:0] outs();
    return {bus.ram_address, bus.ram_in, bus.ram_load, bus.pixel, bus.pixel_valid,
            bus.line_start, bus.frame_start, bus.busy, bus.done};
  endfunction

  task automatic push_frame(input bit use_fill, input logic [15:0] fillv);
    logic [15:0] w;
    exp_q.delete();
    for (int n = 0; n < DEPTH; n++) begin
      w = use_fill ? fillv : preload_word(n);
      for (int b = 0; b < 16; b++) exp_q.push_back(w[b]);
    end
  endtask

  // start sampled at the next edge; returns in the FETCH cycle
  task automatic pulse_start();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // -------------------------------------------------------------------------
  task automatic test_reset();
    bus.start = 1'b0; bus.clear = 1'b0; bus.fill = 16'h0000; bus.pixel_ready = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (outs() !== 35'h0)
      $display("FAIL reset_outputs got=%h exp=%h", outs(), 35'h0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (outs() !== 35'h0)
      $display("FAIL idle_after_reset got=%h exp=%h", outs(), 35'h0);
    $display("reset: outputs checked during and after reset");
  endtask

  // clear and start together, plus a start pulse while busy
  task automatic test_clear();
    int          writes, bad;
    logic [11:0] next_addr;
    logic [2:0]  exp_st;
    bus.clear = 1'b1; bus.start = 1'b1; bus.fill = 16'hA5C3;
    @(negedge clk);
    bus.clear = 1'b0; bus.start = 1'b0; bus.fill = 16'h0000;
    writes = 0; next_addr = 12'h000;
    for (int cyc = 1; cyc <= DEPTH + 10; cyc++) begin
      exp_st = {1'(cyc <= DEPTH), 1'(cyc == DEPTH + 1), 1'(cyc <= DEPTH)};
      n_checks++;
      if ({bus.busy, bus.done, bus.ram_load} !== exp_st || bus.pixel_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL clear_timing cyc=%0d got busy/done/load=%b valid=%b exp=%b valid=0",
                 cyc, {bus.busy, bus.done, bus.ram_load}, bus.pixel_valid, exp_st);
      end
      if (bus.ram_load) begin
        n_checks++;
        if (bus.ram_address !== next_addr || bus.ram_in !== 16'hA5C3) begin
          n_fail++;
          $display("FAIL clear_write cyc=%0d got addr=%h data=%h exp addr=%h data=a5c3",
                   cyc, bus.ram_address, bus.ram_in, next_addr);
        end
        next_addr = next_addr + 12'd1;
        writes++;
      end
      bus.start = (cyc == 5);
      @(negedge clk);
    end
    bus.start = 1'b0;
    n_checks++;
    if (writes !== DEPTH) begin
      n_fail++;
      $display("FAIL clear_write_count got=%0d exp=%0d", writes, DEPTH);
    end
    bad = 0;
    for (int n = 0; n < DEPTH; n++) if (mem[n] !== 16'hA5C3) bad++;
    n_checks++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL clear_ram_contents got=%0d bad words exp=0", bad);
    end
    $display("clear: fill=a5c3 writes=%0d", writes);
  endtask

  // scan of the cleared RAM must repeat the fill pattern LSB-first
  task automatic test_clear_pattern();
    int          pix, dones;
    logic        e;
    logic [15:0] first;
    push_frame(1'b1, 16'hA5C3);
    bus.pixel_ready = 1'b1;
    pulse_start();
    pix = 0; dones = 0; first = '0;
    for (int cyc = 0; cyc < NPIX * 2 && dones == 0; cyc++) begin
      @(negedge clk);
      if (bus.done) dones++;
      if (bus.pixel_valid) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 1'bx;
        n_checks++;
        if (bus.pixel !== e) begin
          n_fail++;
          $display("FAIL fill_pixel idx=%0d got=%b exp=%b", pix, bus.pixel, e);
        end
        if (pix < 16) first = {bus.pixel, first[15:1]};
        pix++;
      end
    end
    n_checks++;
    if (first !== 16'hA5C3 || pix !== NPIX || dones !== 1) begin
      n_fail++;
      $display("FAIL fill_scan got first=%h pix=%0d done=%0d exp first=a5c3 pix=%0d done=1",
               first, pix, dones, NPIX);
    end
    $display("clear scan: %0d pixels, first word %h", pix, first);
  endtask

  task automatic test_preload();
    tb_we = 1'b1;
    for (int n = 0; n < DEPTH; n++) begin
      tb_addr = 12'(n);
      tb_data = preload_word(n);
      @(negedge clk);
    end
    tb_we = 1'b0;
    $display("preload: %0d words written", DEPTH);
  endtask

  task automatic test_scan_order();
    int          pix, lines, frames, dones, busy_cyc, first_cyc;
    logic        e;
    logic [15:0] w1, wl;
    push_frame(1'b0, 16'h0000);
    bus.pixel_ready = 1'b1;
    pulse_start();
    n_checks++;
    if ({bus.busy, bus.pixel_valid, bus.ram_load, bus.ram_address} !== {3'b100, 12'h000}) begin
      n_fail++;
      $display("FAIL scan_fetch_cycle got busy/valid/load=%b addr=%h exp=100 addr=000",
               {bus.busy, bus.pixel_valid, bus.ram_load}, bus.ram_address);
    end
    busy_cyc = bus.busy ? 1 : 0;
    pix = 0; lines = 0; frames = 0; dones = 0; first_cyc = -1; w1 = '0; wl = '0;
    for (int cyc = 1; cyc <= NPIX * 2 && dones == 0; cyc++) begin
      @(negedge clk);
      if (bus.busy) busy_cyc++;
      if (bus.done) dones++;
      n_checks++;
      if (bus.ram_load !== 1'b0) begin
        n_fail++;
        $display("FAIL scan_no_load cyc=%0d got=%b exp=0", cyc, bus.ram_load);
      end
      if (bus.pixel_valid) begin
        if (first_cyc < 0) first_cyc = cyc;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 1'bx;
        n_checks++;
        if (bus.pixel !== e || bus.line_start !== 1'(pix % LINE_PIX == 0) ||
            bus.frame_start !== 1'(pix == 0)) begin
          n_fail++;
          $display("FAIL scan_pixel idx=%0d got p/ls/fs=%b%b%b exp=%b%b%b", pix,
                   bus.pixel, bus.line_start, bus.frame_start,
                   e, 1'(pix % LINE_PIX == 0), 1'(pix == 0));
        end
        if (bus.line_start)  lines++;
        if (bus.frame_start) frames++;
        if (pix >= 16 && pix < 32) w1 = {bus.pixel, w1[15:1]};
        if (pix >= NPIX - 16)      wl = {bus.pixel, wl[15:1]};
        pix++;
      end
    end
    repeat (5) begin
      @(negedge clk);
      if (bus.done) dones++;
      if (bus.busy) busy_cyc++;
    end
    n_checks++;
    if (first_cyc !== 1) begin
      n_fail++;
      $display("FAIL scan_first_valid got cycle=%0d exp=1 after fetch", first_cyc);
    end
    n_checks++;
    if (w1 !== 16'h0001 || wl !== 16'h0EFF) begin
      n_fail++;
      $display("FAIL scan_words got w1=%h wlast=%h exp w1=0001 wlast=0eff", w1, wl);
    end
    n_checks++;
    if (pix !== NPIX || dones !== 1 || busy_cyc !== DEPTH * 17) begin
      n_fail++;
      $display("FAIL scan_totals got pix=%0d done=%0d busy=%0d exp pix=%0d done=1 busy=%0d",
               pix, dones, busy_cyc, NPIX, DEPTH * 17);
    end
    n_checks++;
    if (lines !== LINES || frames !== 1) begin
      n_fail++;
      $display("FAIL scan_markers got lines=%0d frames=%0d exp lines=%0d frames=1",
               lines, frames, LINES);
    end
    $display("scan order: %0d pixels, %0d line marks, %0d frame marks, %0d busy cycles",
             pix, lines, frames, busy_cyc);
  endtask

  task automatic test_backpressure();
    int   pix, dones;
    logic e, hold;
    logic [2:0] held;
    push_frame(1'b0, 16'h0000);
    pulse_start();
    pix = 0; dones = 0; hold = 1'b0; held = '0;
    for (int cyc = 1; cyc <= NPIX * 8 && dones == 0; cyc++) begin
      @(negedge clk);
      if (bus.done) dones++;
      if (hold) begin
        n_checks++;
        if ({bus.pixel_valid, bus.pixel, bus.line_start, bus.frame_start} !== {1'b1, held}) begin
          n_fail++;
          $display("FAIL bp_stable cyc=%0d got v/p/ls/fs=%b exp=%b", cyc,
                   {bus.pixel_valid, bus.pixel, bus.line_start, bus.frame_start}, {1'b1, held});
        end
      end
      bus.pixel_ready = 1'($urandom_range(0, 1));
      bus.start       = (cyc == 40);
      if (bus.pixel_valid && bus.pixel_ready) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 1'bx;
        n_checks++;
        if (bus.pixel !== e) begin
          n_fail++;
          $display("FAIL bp_pixel idx=%0d got=%b exp=%b", pix, bus.pixel, e);
        end
        pix++;
      end
      hold = bus.pixel_valid && !bus.pixel_ready;
      held = {bus.pixel, bus.line_start, bus.frame_start};
    end
    bus.start = 1'b0;
    bus.pixel_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n_checks++;
      if (bus.busy !== 1'b0 || bus.pixel_valid !== 1'b0 || bus.done !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_no_rescan cyc=%0d got busy/valid/done=%b%b%b exp=000",
                 i, bus.busy, bus.pixel_valid, bus.done);
      end
    end
    n_checks++;
    if (pix !== NPIX || dones !== 1 || exp_q.size() !== 0) begin
      n_fail++;
      $display("FAIL bp_totals got pix=%0d done=%0d left=%0d exp pix=%0d done=1 left=0",
               pix, dones, exp_q.size(), NPIX);
    end
    $display("backpressure: %0d pixels transferred with random ready", pix);
  endtask

  task automatic test_reset_mid_scan();
    int   pix, dones;
    logic e;
    bus.pixel_ready = 1'b1;
    pulse_start();
    repeat (60) @(negedge clk);
    n_checks++;
    if (bus.pixel_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_mid_shift got valid=%b exp=1", bus.pixel_valid);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (outs() !== 35'h0) begin
      n_fail++;
      $display("FAIL rst_async got=%h exp=%h", outs(), 35'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus.done || bus.busy) dones++;
    end
    n_checks++;
    if (dones !== 0) begin
      n_fail++;
      $display("FAIL rst_abort got busy/done cycles=%0d exp=0", dones);
    end
    push_frame(1'b0, 16'h0000);
    pulse_start();
    n_checks++;
    if (bus.ram_address !== 12'h000 || bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_restart_addr got addr=%h busy=%b exp addr=000 busy=1",
               bus.ram_address, bus.busy);
    end
    pix = 0; dones = 0;
    for (int cyc = 1; cyc <= NPIX * 2 && dones == 0; cyc++) begin
      @(negedge clk);
      if (bus.done) dones++;
      if (bus.pixel_valid) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 1'bx;
        n_checks++;
        if (bus.pixel !== e || bus.frame_start !== 1'(pix == 0)) begin
          n_fail++;
          $display("FAIL rst_rescan idx=%0d got p/fs=%b%b exp=%b%b", pix,
                   bus.pixel, bus.frame_start, e, 1'(pix == 0));
        end
        pix++;
      end
    end
    n_checks++;
    if (pix !== NPIX || dones !== 1) begin
      n_fail++;
      $display("FAIL rst_rescan_totals got pix=%0d done=%0d exp pix=%0d done=1", pix, dones, NPIX);
    end
    $display("reset mid-scan: rescan %0d pixels from address 0", pix);
  endtask

  initial begin
    test_reset();
    test_clear();
    test_clear_pattern();
    test_preload();
    test_scan_order();
    test_backpressure();
    test_reset_mid_scan();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog simulation time limit reached, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

endmodule
